io_input_conditioner: RTL and testbench
=======================================

// Module: io_input_conditioner
// PURPOSE
//   Conditions raw board inputs (slide switches, push-buttons) before they reach the pipelined core's
//   io_sw_i / io_btn_i ports. Synchronises each asynchronous pad bit into clk_i, debounces it with a
//   per-bit counter and presents clean, glitch-free levels. Optional one-cycle press pulses for buttons.
//   Sits between the board pins and the core, in the divided-clock domain.
// PARAMETERS
//   SW_WIDTH         9       number of switch inputs
//   BTN_WIDTH        4       number of push-button inputs (active-low, released = 1)
//   SYNC_STAGES      2       synchroniser flops per bit; legal range 2..4
//   DEBOUNCE_CYCLES  125000  consecutive stable cycles needed to accept a new level; >= 1 (10 ms @ 12.5 MHz)
// PORTS
//   clk_i          in   1          core clock (divided clock), rising edge
//   rst_i          in   1          synchronous, active-high reset
//   sw_raw_i       in   SW_WIDTH   asynchronous switch pads
//   btn_raw_i      in   BTN_WIDTH  asynchronous button pads, active-low
//   sw_o           out  SW_WIDTH   debounced switch levels
//   btn_o          out  BTN_WIDTH  debounced button levels, active-low (same polarity as pads)
//   btn_press_o    out  BTN_WIDTH  one-cycle pulse per press (only with IO_BTN_EDGE_EN)
// BEHAVIOUR
//   - Reset (rst_i=1 at a clk_i edge): sync flops <= idle value (switches 0, buttons 1); sw_o <= 0;
//     btn_o <= '1; btn_press_o <= 0; all counters <= 0; all bit FSMs <= DB_STABLE. Reset overrides everything.
//   - Per bit: sync chain of SYNC_STAGES flops -> s; FSM with registered stable level q (drives output).
//     DB_STABLE: cnt=0; if s != q -> DB_PENDING, cnt <= 1.
//     DB_PENDING: if s == q -> DB_STABLE, cnt <= 0 (glitch rejected, output unchanged).
//       else if cnt == DEBOUNCE_CYCLES -> q <= s, cnt <= 0, DB_STABLE.
//       else cnt <= cnt + 1.
//   - DEBOUNCE_CYCLES=1: q follows s one cycle after the first differing sample.
//   - Latency: a clean step on a pad appears on the output exactly SYNC_STAGES + DEBOUNCE_CYCLES + 1
//     clk_i edges after the edge that first samples it. Any pulse shorter than DEBOUNCE_CYCLES
//     synchronised cycles never reaches the output.
//   - Counter width CNT_W = $clog2(DEBOUNCE_CYCLES+1); no wrap is possible (max value DEBOUNCE_CYCLES).
//   - Bits are fully independent; simultaneous changes on several bits are debounced in parallel with
//     identical latency.
//   - Reset mid-debounce discards the pending change; the level must be re-qualified from scratch.
// CONFIGURATION
//   IO_BTN_EDGE_EN defined: btn_press_o[i] = 1 for exactly one cycle, the cycle after btn_o[i] goes 1->0
//     (registered); no pulse on release, no pulse out of reset even if a key is held.
//   IO_BTN_EDGE_EN undefined: btn_press_o tied to 0, no edge registers inferred.
// STRUCTURE
//   Package io_cond_pkg: typedef enum logic {DB_STABLE, DB_PENDING} db_state_e; localparams
//     SW_IDLE = 1'b0, BTN_IDLE = 1'b1; function cnt_width(int cycles) returning $clog2(cycles+1).
//   Sub-module io_debounce_bit (params SYNC_STAGES, DEBOUNCE_CYCLES, IDLE_VAL): sync chain + FSM + counter
//     for one bit; top instantiates it SW_WIDTH + BTN_WIDTH times via generate, plus the optional edge logic.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2 unless stated)
//   1. Assert rst_i 3 cycles with sw_raw_i=9'h1FF, btn_raw_i=4'h0 -> during/after reset sw_o=0, btn_o=4'hF,
//      btn_press_o=0; release -> outputs change only after full latency (7 edges).
//   2. sw_raw_i[0] 0->1 held -> sw_o[0] rises exactly 7 edges after first sampling edge; other bits stay 0.
//   3. btn_raw_i[2] low for 3 cycles then high -> btn_o stays 4'hF, btn_press_o stays 0 (glitch rejected).
//   4. btn_raw_i[1] held low 20 cycles -> btn_o=4'b1101; with IO_BTN_EDGE_EN btn_press_o=4'b0010 for exactly
//      1 cycle, then 0; release -> btn_o back to 4'hF, no pulse.
//   5. sw_raw_i[3] toggling every 2 cycles for 40 cycles then held 1 -> sw_o[3] stays 0 until 7 edges after
//      the final hold begins.
//   6. rst_i pulsed 1 cycle while sw_raw_i[5] pending at cnt=3 -> sw_o[5] stays 0, rises 7 edges after reset.

Source files
------------

// File: rtl/io_cond_pkg.sv
// io_cond_pkg: shared types and constants for the board input conditioner.
//   db_state_e : per-bit debounce FSM state
//   SW_IDLE    : idle/reset level of a switch pad (off)
//   BTN_IDLE   : idle/reset level of a button pad (released, active-low)
//   cnt_width  : width of a counter able to hold 0..cycles
package io_cond_pkg;

  typedef enum logic {
    DB_STABLE  = 1'b0,
    DB_PENDING = 1'b1
  } db_state_e;

  localparam logic SW_IDLE  = 1'b0;
  localparam logic BTN_IDLE = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_debounce_bit.sv
// io_debounce_bit: synchroniser chain plus debounce FSM for one pad bit.
//   clk_i   in   core clock, rising edge
//   rst_i   in   synchronous active-high reset
//   raw_i   in   asynchronous pad level
//   level_o out  debounced level (IDLE_VAL out of reset)
// A new level is accepted only after it has been seen on the synchronised
// sample for DEBOUNCE_CYCLES consecutive cycles; shorter excursions are dropped.
module io_debounce_bit
  import io_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 125000,
  parameter logic        IDLE_VAL        = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned     CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    unique case (state_q)
      DB_STABLE: begin
        cnt_d = '0;
        if (s != level_q) begin
          state_d = DB_PENDING;
          cnt_d   = CNT_ONE;
        end
      end
      DB_PENDING: begin
        if (s == level_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          level_d = s;
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= {SYNC_STAGES{IDLE_VAL}};
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      level_q <= IDLE_VAL;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/io_input_conditioner.sv
// io_input_conditioner: synchronises and debounces board switches and buttons.
//   clk_i        in   core (divided) clock, rising edge
//   rst_i        in   synchronous active-high reset
//   sw_raw_i     in   asynchronous switch pads
//   btn_raw_i    in   asynchronous button pads, active-low
//   sw_o         out  debounced switch levels
//   btn_o        out  debounced button levels, active-low
//   btn_press_o  out  one-cycle pulse per press
// Build option: define IO_BTN_EDGE_EN to generate press pulses; otherwise
// btn_press_o is tied low and no edge registers exist.
module io_input_conditioner
  import io_cond_pkg::*;
#(
  parameter int unsigned SW_WIDTH        = 9,
  parameter int unsigned BTN_WIDTH       = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 125000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SW_WIDTH-1:0]  sw_raw_i,
  input  logic [BTN_WIDTH-1:0] btn_raw_i,
  output logic [SW_WIDTH-1:0]  sw_o,
  output logic [BTN_WIDTH-1:0] btn_o,
  output logic [BTN_WIDTH-1:0] btn_press_o
);

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    io_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_VAL       (SW_IDLE)
    ) u_db (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .raw_i  (sw_raw_i[i]),
      .level_o(sw_o[i])
    );
  end

  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
    io_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_VAL       (BTN_IDLE)
    ) u_db (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .raw_i  (btn_raw_i[i]),
      .level_o(btn_o[i])
    );
  end

`ifdef IO_BTN_EDGE_EN
  logic [BTN_WIDTH-1:0] btn_dly_q, btn_dly_d;
  logic [BTN_WIDTH-1:0] press_q, press_d;

  // Delay register resets to released so reset itself never looks like a press.
  always_comb begin
    btn_dly_d = btn_o;
    press_d   = btn_dly_q & ~btn_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_dly_q <= '1;
      press_q   <= '0;
    end else begin
      btn_dly_q <= btn_dly_d;
      press_q   <= press_d;
    end
  end

  assign btn_press_o = press_q;
`else
  assign btn_press_o = '0;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [8:0] sw_raw;
  logic [3:0] btn_raw;
  logic [8:0] sw_o;
  logic [3:0] btn_o;
  logic [3:0] btn_press_o;
  logic [8:0] sw2_o;
  logic [3:0] btn2_o;
  logic [3:0] press2_o;

  always #5 clk = ~clk;

  io_input_conditioner #(
    .SW_WIDTH       (9),
    .BTN_WIDTH      (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .sw_raw_i   (sw_raw),
    .btn_raw_i  (btn_raw),
    .sw_o       (sw_o),
    .btn_o      (btn_o),
    .btn_press_o(btn_press_o)
  );

  // Boundary configuration: shortest debounce, longest-but-one sync chain.
  io_input_conditioner #(
    .SW_WIDTH       (9),
    .BTN_WIDTH      (4),
    .SYNC_STAGES    (3),
    .DEBOUNCE_CYCLES(1)
  ) dut2 (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .sw_raw_i   (sw_raw),
    .btn_raw_i  (btn_raw),
    .sw_o       (sw2_o),
    .btn_o      (btn2_o),
    .btn_press_o(press2_o)
  );

`ifdef IO_BTN_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  typedef struct {
    int unsigned due;
    logic [8:0]  sw;
    logic [3:0]  btn;
    logic [3:0]  press;
    int          tid;
    bit          chk2;
    logic [8:0]  sw2;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input int unsigned due, input logic [8:0] sw, input logic [3:0] btn,
                      input logic [3:0] press, input int tid, input bit chk2,
                      input logic [8:0] sw2);
    exp_t e;
    e.due = due; e.sw = sw; e.btn = btn; e.press = press;
    e.tid = tid; e.chk2 = chk2; e.sw2 = sw2;
    sb.push_back(e);
  endtask

  // Scoreboard: expectations are popped and compared when their cycle arrives.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        check($sformatf("t%0d_missed@%0d", e.tid, e.due), cyc, e.due);
      end else begin
        check($sformatf("t%0d_sw@%0d", e.tid, e.due), sw_o, e.sw);
        check($sformatf("t%0d_btn@%0d", e.tid, e.due), btn_o, e.btn);
        check($sformatf("t%0d_press@%0d", e.tid, e.due), btn_press_o, e.press);
        if (e.chk2) begin
          check($sformatf("t%0d_sw2@%0d", e.tid, e.due), sw2_o, e.sw2);
          check($sformatf("t%0d_btn2@%0d", e.tid, e.due), btn2_o, 4'hF);
          check($sformatf("t%0d_press2@%0d", e.tid, e.due), press2_o, 4'h0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int unsigned lim;
    lim = cyc + 200;
    while (sb.size() > 0 && cyc < lim) tick();
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    sw_raw  = '0;
    btn_raw = 4'hF;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    logic [3:0]  b, p;

    // 1: reset holds idle outputs despite active pads; release then full latency.
    rst_i   = 1'b1;
    sw_raw  = 9'h1FF;
    btn_raw = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      push(cyc, 9'h000, 4'hF, 4'h0, 1, 1'b0, '0);
    end
    rst_i = 1'b0;
    c = cyc;
    for (int unsigned k = 1; k <= 9; k++) begin
      p = (EDGE && k == 8) ? 4'hF : 4'h0;
      if (k >= 7) push(c + k, 9'h1FF, 4'h0, p, 1, 1'b0, '0);
      else        push(c + k, 9'h000, 4'hF, p, 1, 1'b0, '0);
    end
    drain();
    do_reset();

    // 2: single switch step; also the DEBOUNCE_CYCLES=1 / SYNC_STAGES=3 instance.
    c = cyc;
    sw_raw = 9'h001;
    for (int unsigned k = 1; k <= 9; k++)
      push(c + k, (k >= 7) ? 9'h001 : 9'h000, 4'hF, 4'h0, 2, 1'b1,
           (k >= 5) ? 9'h001 : 9'h000);
    drain();
    do_reset();

    // 3: 3-cycle button glitch is rejected.
    c = cyc;
    btn_raw = 4'b1011;
    for (int unsigned k = 1; k <= 12; k++)
      push(c + k, 9'h000, 4'hF, 4'h0, 3, 1'b0, '0);
    tick(); tick(); tick();
    btn_raw = 4'hF;
    drain();

    // 4: held press, single pulse, clean release without pulse.
    c = cyc;
    btn_raw = 4'b1101;
    for (int unsigned k = 1; k <= 32; k++) begin
      b = (k >= 7 && k < 27) ? 4'b1101 : 4'hF;
      p = (EDGE && k == 8) ? 4'b0010 : 4'h0;
      push(c + k, 9'h000, b, p, 4, 1'b0, '0);
    end
    for (int i = 0; i < 20; i++) tick();
    btn_raw = 4'hF;
    drain();
    do_reset();

    // 5: bouncing switch never qualifies until the final steady hold.
    c = cyc;
    for (int unsigned k = 1; k <= 48; k++)
      push(c + k, (k >= 47) ? 9'h008 : 9'h000, 4'hF, 4'h0, 5, 1'b0, '0);
    for (int unsigned k = 0; k < 40; k++) begin
      sw_raw = (((k / 2) % 2) == 0) ? 9'h008 : 9'h000;
      tick();
    end
    sw_raw = 9'h008;
    drain();
    do_reset();

    // 6: reset while pending at cnt=3 discards progress.
    c = cyc;
    sw_raw = 9'h020;
    for (int unsigned k = 1; k <= 14; k++)
      push(c + k, (k >= 13) ? 9'h020 : 9'h000, 4'hF, 4'h0, 6, 1'b0, '0);
    for (int i = 0; i < 5; i++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
